// File: rtl/alu_operand_stage.sv
// Operand-select stage between decode and ALU: resolves MEM/WB forwarding,
// stalls on load-use, and buffers results in a two-entry head/skid register.
module alu_operand_stage #(
   parameter int FWD_EN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_rs1_addr,
   input  logic [4:0]  in_rs2_addr,
   input  logic [4:0]  in_rd_addr,
   input  logic [31:0] in_rs1_data,
   input  logic [31:0] in_rs2_data,
   input  logic [31:0] in_imm,
   input  logic [31:0] in_pc,
   input  logic [2:0]  in_alu_op,
   input  logic        in_op1_sel,
   input  logic [1:0]  in_op2_sel,
   input  logic        fwd_mem_valid,
   input  logic        fwd_mem_pend,
   input  logic [4:0]  fwd_mem_rd,
   input  logic [31:0] fwd_mem_data,
   input  logic        fwd_wb_valid,
   input  logic [4:0]  fwd_wb_rd,
   input  logic [31:0] fwd_wb_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [2:0]  out_alu_op,
   output logic [4:0]  out_rd_addr,
   output logic [31:0] out_pc
);

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [4:0]  rd;
      logic [31:0] pc;
   } entry_t;

   localparam logic FWD_ON = (FWD_EN != 0);

   entry_t      head_r;
   entry_t      skid_r;
   entry_t      new_entry_s;
   logic        head_valid_r;
   logic        skid_valid_r;
   logic        ready_en_r;
   logic [31:0] rs1_s;
   logic [31:0] rs2_s;
   logic        rs1_haz_s;
   logic        rs2_haz_s;
   logic        load_hazard_s;
   logic        capture_s;
   logic        fire_s;

   function automatic logic [31:0] resolve(
      input logic [4:0]  addr,
      input logic [31:0] rf_data,
      input logic        mem_valid,
      input logic [4:0]  mem_rd,
      input logic [31:0] mem_data,
      input logic        wb_valid,
      input logic [4:0]  wb_rd,
      input logic [31:0] wb_data
   );
      logic [31:0] r;
      if (addr == 5'd0) begin
         r = 32'd0;
      end else if (FWD_ON && mem_valid && (mem_rd == addr)) begin
         r = mem_data;
      end else if (FWD_ON && wb_valid && (wb_rd == addr)) begin
         r = wb_data;
      end else begin
         r = rf_data;
      end
      return r;
   endfunction

   // Forwarding resolution, load-use detection and operand selection
   always_comb begin
      rs1_s = resolve(in_rs1_addr, in_rs1_data, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                      fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
      rs2_s = resolve(in_rs2_addr, in_rs2_data, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                      fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
      rs1_haz_s = (in_op1_sel == 1'b0) && (in_rs1_addr != 5'd0) && fwd_mem_valid
                  && fwd_mem_pend && (fwd_mem_rd == in_rs1_addr);
      // op2_sel 3 is reserved and behaves as rs2, so it must also stall
      rs2_haz_s = ((in_op2_sel == 2'd0) || (in_op2_sel == 2'd3)) && (in_rs2_addr != 5'd0)
                  && fwd_mem_valid && fwd_mem_pend && (fwd_mem_rd == in_rs2_addr);
      load_hazard_s = FWD_ON && in_valid && (rs1_haz_s || rs2_haz_s);

      new_entry_s.a  = in_op1_sel ? in_pc : rs1_s;
      new_entry_s.op = in_alu_op;
      new_entry_s.rd = in_rd_addr;
      new_entry_s.pc = in_pc;
      case (in_op2_sel)
         2'd0:    new_entry_s.b = rs2_s;
         2'd1:    new_entry_s.b = in_imm;
         2'd2:    new_entry_s.b = 32'd4;
         default: new_entry_s.b = rs2_s;
      endcase
   end

   assign in_ready  = ready_en_r && !skid_valid_r && !load_hazard_s && !flush;
   assign capture_s = in_valid && in_ready;
   assign fire_s    = head_valid_r && out_ready;

   // Head/skid storage; flush outranks both capture and fire
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_r       <= '0;
         skid_r       <= '0;
         head_valid_r <= 1'b0;
         skid_valid_r <= 1'b0;
         ready_en_r   <= 1'b0;
      end else begin
         ready_en_r <= 1'b1;
         if (flush) begin
            head_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
         end else if (skid_valid_r) begin
            if (fire_s) begin
               head_r       <= skid_r;
               skid_valid_r <= 1'b0;
            end
         end else if (capture_s) begin
            if (!head_valid_r || out_ready) begin
               head_r       <= new_entry_s;
               head_valid_r <= 1'b1;
            end else begin
               skid_r       <= new_entry_s;
               skid_valid_r <= 1'b1;
            end
         end else if (fire_s) begin
            head_valid_r <= 1'b0;
         end
      end
   end

   assign out_valid   = head_valid_r;
   assign out_a       = head_r.a;
   assign out_b       = head_r.b;
   assign out_alu_op  = head_r.op;
   assign out_rd_addr = head_r.rd;
   assign out_pc      = head_r.pc;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus a random
// run compared against a queue-based FIFO reference model.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready;
   logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
   logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
   logic [2:0]  in_alu_op;
   logic        in_op1_sel;
   logic [1:0]  in_op2_sel;
   logic        fwd_mem_valid, fwd_mem_pend;
   logic [4:0]  fwd_mem_rd;
   logic [31:0] fwd_mem_data;
   logic        fwd_wb_valid;
   logic [4:0]  fwd_wb_rd;
   logic [31:0] fwd_wb_data;
   logic        out_valid, out_ready;
   logic [31:0] out_a, out_b, out_pc;
   logic [2:0]  out_alu_op;
   logic [4:0]  out_rd_addr;

   alu_operand_stage #(.FWD_EN(1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_pc(in_pc),
      .in_alu_op(in_alu_op), .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel),
      .fwd_mem_valid(fwd_mem_valid), .fwd_mem_pend(fwd_mem_pend),
      .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
      .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_alu_op(out_alu_op),
      .out_rd_addr(out_rd_addr), .out_pc(out_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [4:0]  rd;
      logic [31:0] pc;
   } exp_t;

   exp_t q[$];
   bit   m_rdy;
   int   n_cmp  = 0;
   int   n_fail = 0;

   function automatic logic [31:0] m_res(input logic [4:0] addr, input logic [31:0] rf);
      if (addr == 5'd0) return 32'd0;
      if (fwd_mem_valid && fwd_mem_rd == addr) return fwd_mem_data;
      if (fwd_wb_valid && fwd_wb_rd == addr) return fwd_wb_data;
      return rf;
   endfunction

   function automatic bit m_hazard();
      bit h1, h2;
      h1 = !in_op1_sel && in_rs1_addr != 5'd0 && fwd_mem_valid && fwd_mem_pend
           && fwd_mem_rd == in_rs1_addr;
      h2 = (in_op2_sel == 2'd0 || in_op2_sel == 2'd3) && in_rs2_addr != 5'd0
           && fwd_mem_valid && fwd_mem_pend && fwd_mem_rd == in_rs2_addr;
      return in_valid && (h1 || h2);
   endfunction

   function automatic bit m_ready();
      return m_rdy && q.size() < 2 && !m_hazard() && !flush;
   endfunction

   // Advance one clock edge and update the reference FIFO accordingly.
   task automatic tick();
      exp_t e;
      bit   cap, fire, fl, r;
      r    = rst;
      fl   = flush;
      cap  = in_valid && m_ready();
      fire = q.size() > 0 && out_ready;
      e.a  = in_op1_sel ? in_pc : m_res(in_rs1_addr, in_rs1_data);
      e.b  = (in_op2_sel == 2'd1) ? in_imm : (in_op2_sel == 2'd2) ? 32'd4
           : m_res(in_rs2_addr, in_rs2_data);
      e.op = in_alu_op;
      e.rd = in_rd_addr;
      e.pc = in_pc;
      @(posedge clk);
      if (r || rst) begin
         q.delete();
         m_rdy = 1'b0;
      end else begin
         if (fl) q.delete();
         else begin
            if (fire) void'(q.pop_front());
            if (cap) q.push_back(e);
         end
         m_rdy = 1'b1;
      end
      #1;
   endtask

   task automatic idle();
      flush = 1'b0; in_valid = 1'b0;
      in_rs1_addr = 5'd0; in_rs2_addr = 5'd0; in_rd_addr = 5'd0;
      in_rs1_data = 32'd0; in_rs2_data = 32'd0; in_imm = 32'd0; in_pc = 32'd0;
      in_alu_op = 3'd0; in_op1_sel = 1'b0; in_op2_sel = 2'd0;
      fwd_mem_valid = 1'b0; fwd_mem_pend = 1'b0; fwd_mem_rd = 5'd0; fwd_mem_data = 32'd0;
      fwd_wb_valid = 1'b0; fwd_wb_rd = 5'd0; fwd_wb_data = 32'd0;
   endtask

   task automatic drain();
      idle();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_reset();
      idle();
      out_ready = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out_a !== 32'd0 || out_b !== 32'd0 || out_pc !== 32'd0
          || out_alu_op !== 3'd0 || out_rd_addr !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b a=%h b=%h pc=%h op=%h rd=%h, required all 0",
                  out_valid, out_a, out_b, out_pc, out_alu_op, out_rd_addr);
      end
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready);
      end
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL ready_before_first_edge: got %b required 0", in_ready);
      end
      tick();
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL ready_after_first_edge: got %b required 1", in_ready);
      end
   endtask

   task automatic test_forward_priority();
      idle();
      out_ready = 1'b1;
      in_valid = 1'b1; in_rs1_addr = 5'd5; in_rs1_data = 32'h0BAD0BAD; in_op1_sel = 1'b0;
      in_op2_sel = 2'd1; in_imm = 32'h00000123;
      fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'hAAAA0000;
      fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd5; fwd_wb_data = 32'h11111111;
      tick();
      idle();
      fwd_mem_data = 32'h55555555;
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_a !== 32'hAAAA0000 || out_b !== 32'h00000123) begin
         n_fail++;
         $display("FAIL fwd_priority: valid=%b a=%h b=%h required 1 aaaa0000 00000123",
                  out_valid, out_a, out_b);
      end
      drain();
   endtask

   task automatic test_x0_source();
      idle();
      out_ready = 1'b1;
      in_valid = 1'b1; in_rs2_addr = 5'd0; in_rs2_data = 32'h12345678; in_op2_sel = 2'd0;
      in_op1_sel = 1'b1; in_pc = 32'h40;
      fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd0; fwd_wb_data = 32'hFFFFFFFF;
      tick();
      idle();
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_b !== 32'd0 || out_a !== 32'h40) begin
         n_fail++;
         $display("FAIL x0_source: valid=%b a=%h b=%h required 1 00000040 00000000",
                  out_valid, out_a, out_b);
      end
      drain();
   endtask

   task automatic test_load_use();
      idle();
      out_ready = 1'b1;
      in_valid = 1'b1; in_rs2_addr = 5'd3; in_op2_sel = 2'd0; in_op1_sel = 1'b1;
      in_rs2_data = 32'h0000F00D;
      fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_pend = 1'b1; fwd_mem_data = 32'hDEADBEEF;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL load_use_stall[%0d]: in_ready=%b required 0", i, in_ready);
         end
         tick();
      end
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL load_use_no_capture: out_valid=%b required 0", out_valid);
      end
      fwd_mem_pend = 1'b0; fwd_mem_data = 32'h12345678;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL load_use_release: in_ready=%b required 1", in_ready);
      end
      tick();
      idle();
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_b !== 32'h12345678) begin
         n_fail++;
         $display("FAIL load_use_data: valid=%b b=%h required 1 12345678", out_valid, out_b);
      end
      drain();
   endtask

   task automatic test_backpressure();
      logic [31:0] got[$];
      int          k;
      idle();
      k = 0;
      in_op1_sel = 1'b1; in_op2_sel = 2'd2;
      for (int cyc = 0; cyc < 30; cyc++) begin
         out_ready = (cyc >= 3);
         in_valid  = (k < 4);
         in_pc     = 32'(k * 4);
         #1;
         if (cyc == 2) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin
               n_fail++; $display("FAIL backpressure_full: in_ready=%b required 0", in_ready);
            end
         end
         if (out_valid && out_ready) got.push_back(out_pc);
         if (in_valid && in_ready) k++;
         tick();
      end
      n_cmp++;
      if (got.size() != 4) begin
         n_fail++; $display("FAIL backpressure_count: got %0d outputs required 4", got.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got[i] !== 32'(i * 4)) begin
               n_fail++;
               $display("FAIL backpressure_order[%0d]: pc=%h required %h", i, got[i], 32'(i * 4));
            end
         end
      end
      drain();
   endtask

   task automatic test_pc_const();
      idle();
      out_ready = 1'b1;
      in_valid = 1'b1; in_op1_sel = 1'b1; in_op2_sel = 2'd2; in_pc = 32'h100;
      in_alu_op = 3'd6; in_rd_addr = 5'd17; in_rs1_data = 32'hCAFE0000;
      tick();
      idle();
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_a !== 32'h100 || out_b !== 32'd4 || out_alu_op !== 3'd6
          || out_rd_addr !== 5'd17 || out_pc !== 32'h100) begin
         n_fail++;
         $display("FAIL pc_const: valid=%b a=%h b=%h op=%h rd=%h pc=%h required 1 100 4 6 11 100",
                  out_valid, out_a, out_b, out_alu_op, out_rd_addr, out_pc);
      end
      drain();
   endtask

   task automatic test_flush();
      idle();
      out_ready = 1'b0;
      in_valid = 1'b1; in_op1_sel = 1'b1; in_op2_sel = 2'd1;
      in_pc = 32'h200; tick();
      in_pc = 32'h204; tick();
      in_pc = 32'h208; flush = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL flush_ready: in_ready=%b required 0", in_ready);
      end
      tick();
      idle();
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_clear: out_valid=%b required 0", out_valid);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_no_capture: out_valid=%b required 0", out_valid);
      end
      drain();
   endtask

   task automatic test_async_reset();
      idle();
      out_ready = 1'b0;
      in_valid = 1'b1; in_op1_sel = 1'b1; in_op2_sel = 2'd1; in_imm = 32'h77;
      in_pc = 32'h300; in_alu_op = 3'd5; in_rd_addr = 5'd9;
      tick();
      idle();
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out_a !== 32'd0 || out_b !== 32'd0 || out_pc !== 32'd0
          || out_alu_op !== 3'd0 || out_rd_addr !== 5'd0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: valid=%b a=%h b=%h pc=%h op=%h rd=%h rdy=%b required all 0",
                  out_valid, out_a, out_b, out_pc, out_alu_op, out_rd_addr, in_ready);
      end
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_no_refire: out_valid=%b required 0", out_valid);
      end
      drain();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         in_valid      = ($urandom_range(0, 3) != 0);
         flush         = ($urandom_range(0, 24) == 0);
         out_ready     = ($urandom_range(0, 2) != 0);
         in_rs1_addr   = 5'($urandom_range(0, 3));
         in_rs2_addr   = 5'($urandom_range(0, 3));
         in_rd_addr    = 5'($urandom);
         in_rs1_data   = $urandom;
         in_rs2_data   = $urandom;
         in_imm        = $urandom;
         in_pc         = $urandom;
         in_alu_op     = 3'($urandom);
         in_op1_sel    = 1'($urandom);
         in_op2_sel    = 2'($urandom);
         fwd_mem_valid = 1'($urandom);
         fwd_mem_pend  = ($urandom_range(0, 3) == 0);
         fwd_mem_rd    = 5'($urandom_range(0, 3));
         fwd_mem_data  = $urandom;
         fwd_wb_valid  = 1'($urandom);
         fwd_wb_rd     = 5'($urandom_range(0, 3));
         fwd_wb_data   = $urandom;
         #1;
         n_cmp++;
         if (in_ready !== m_ready()) begin
            n_fail++;
            $display("FAIL rand_in_ready[%0d]: got %b required %b", i, in_ready, m_ready());
         end
         n_cmp++;
         if (out_valid !== (q.size() > 0)) begin
            n_fail++;
            $display("FAIL rand_out_valid[%0d]: got %b required %b", i, out_valid, q.size() > 0);
         end else if (q.size() > 0) begin
            n_cmp++;
            if (out_a !== q[0].a || out_b !== q[0].b || out_alu_op !== q[0].op
                || out_rd_addr !== q[0].rd || out_pc !== q[0].pc) begin
               n_fail++;
               $display("FAIL rand_fields[%0d]: a=%h b=%h op=%h rd=%h pc=%h required %h %h %h %h %h",
                        i, out_a, out_b, out_alu_op, out_rd_addr, out_pc,
                        q[0].a, q[0].b, q[0].op, q[0].rd, q[0].pc);
            end
         end
         tick();
      end
      drain();
   endtask

   initial begin
      rst = 1'b1;
      m_rdy = 1'b0;
      test_reset();
      test_forward_priority();
      test_x0_source();
      test_load_use();
      test_backpressure();
      test_pc_const();
      test_flush();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
